// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with per-slot anti-ghost blanking and
// frame-synchronous double-buffered display data.
module seg_scan #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] seg_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  dig_en,
    input  logic        load,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        update_done,
    output logic        frame_tick
);

    localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

    typedef enum logic [0:0] {StBlank, StOn} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [27:0]     act_seg_q, act_seg_d;
    logic [3:0]      act_dp_q, act_dp_d;
    logic [27:0]     pend_seg_q, pend_seg_d;
    logic [3:0]      pend_dp_q, pend_dp_d;
    logic            pend_valid_q, pend_valid_d;

    logic [3:0]      an_n_q, an_n_d;
    logic [6:0]      seg_n_q, seg_n_d;
    logic            dp_n_q, dp_n_d;
    logic            update_done_q, update_done_d;
    logic            frame_tick_q, frame_tick_d;

    logic            slot_end;
    logic            boundary;
    logic [6:0]      cur_seg;
    logic            cur_dp;

    assign slot_end = (cnt_q == CntMax);
    assign boundary = slot_end && (idx_q == 2'd3);

    // Slot timing is free-running and independent of dig_en.
    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
        state_d = (cnt_d >= CntBlank) ? StOn : StBlank;
    end

    always_comb begin
        cur_seg = act_seg_q[6:0];
        cur_dp  = act_dp_q[0];
        unique case (idx_q)
            2'd0: begin cur_seg = act_seg_q[6:0];   cur_dp = act_dp_q[0]; end
            2'd1: begin cur_seg = act_seg_q[13:7];  cur_dp = act_dp_q[1]; end
            2'd2: begin cur_seg = act_seg_q[20:14]; cur_dp = act_dp_q[2]; end
            2'd3: begin cur_seg = act_seg_q[27:21]; cur_dp = act_dp_q[3]; end
            default: ;
        endcase
    end

    always_comb begin
        an_n_d  = 4'hF;
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        if (state_q == StOn && dig_en[idx_q]) begin
            an_n_d         = 4'hF;
            an_n_d[idx_q]  = 1'b0;
            seg_n_d        = ~cur_seg;
            dp_n_d         = ~cur_dp;
        end
    end

    // Active data only moves at the frame boundary; a load in that same cycle
    // refills pending after the old pending content has been transferred.
    always_comb begin
        act_seg_d     = act_seg_q;
        act_dp_d      = act_dp_q;
        pend_seg_d    = pend_seg_q;
        pend_dp_d     = pend_dp_q;
        pend_valid_d  = pend_valid_q;
        update_done_d = 1'b0;
        frame_tick_d  = boundary;
        if (boundary && pend_valid_q) begin
            act_seg_d     = pend_seg_q;
            act_dp_d      = pend_dp_q;
            pend_valid_d  = 1'b0;
            update_done_d = 1'b1;
        end
        if (load) begin
            pend_seg_d   = seg_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBlank;
            cnt_q         <= '0;
            idx_q         <= '0;
            act_seg_q     <= '0;
            act_dp_q      <= '0;
            pend_seg_q    <= '0;
            pend_dp_q     <= '0;
            pend_valid_q  <= 1'b0;
            an_n_q        <= 4'hF;
            seg_n_q       <= 7'h7F;
            dp_n_q        <= 1'b1;
            update_done_q <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            act_seg_q     <= act_seg_d;
            act_dp_q      <= act_dp_d;
            pend_seg_q    <= pend_seg_d;
            pend_dp_q     <= pend_dp_d;
            pend_valid_q  <= pend_valid_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            update_done_q <= update_done_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign update_done = update_done_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// Randomized bench for seg_scan against a frame-position reference model.
module tb_seg_scan;

    localparam int unsigned CLK_DIV = 8;
    localparam int unsigned BLANK   = 2;
    localparam int unsigned FRAME   = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] seg_in;
    logic [3:0]  dp_in;
    logic [3:0]  dig_en;
    logic        load;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        update_done;
    logic        frame_tick;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: position inside the frame plus the two data buffers.
    int unsigned pos;
    logic [27:0] m_act_seg, m_pend_seg;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_pv;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_ud, e_ft;

    seg_scan #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .dig_en      (dig_en),
        .load        (load),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .update_done (update_done),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advances the model by one rising edge using the inputs seen at that edge.
    task automatic model_step();
        int unsigned slot, off;
        if (rst) begin
            pos = 0;
            m_act_seg = '0; m_act_dp = '0; m_pend_seg = '0; m_pend_dp = '0; m_pv = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ud = 1'b0; e_ft = 1'b0;
            return;
        end
        slot = pos / CLK_DIV;
        off  = pos % CLK_DIV;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (off >= BLANK && dig_en[slot]) begin
            e_an       = 4'hF;
            e_an[slot] = 1'b0;
            e_seg      = ~m_act_seg[7*slot +: 7];
            e_dp       = ~m_act_dp[slot];
        end
        e_ft = (pos == FRAME - 1);
        e_ud = e_ft && m_pv;
        if (e_ud) begin
            m_act_seg = m_pend_seg;
            m_act_dp  = m_pend_dp;
            m_pv      = 0;
        end
        if (load) begin
            m_pend_seg = seg_in;
            m_pend_dp  = dp_in;
            m_pv       = 1;
        end
        pos = (pos + 1) % FRAME;
    endtask

    task automatic cycle_check();
        @(posedge clk);
        model_step();
        #1;
        check_val("an_n", 32'(an_n), 32'(e_an));
        check_val("seg_n", 32'(seg_n), 32'(e_seg));
        check_val("dp_n", 32'(dp_n), 32'(e_dp));
        check_val("update_done", 32'(update_done), 32'(e_ud));
        check_val("frame_tick", 32'(frame_tick), 32'(e_ft));
    endtask

    task automatic drive(input logic r, input logic ld, input logic [27:0] s,
                         input logic [3:0] d, input logic [3:0] en);
        @(negedge clk);
        rst = r; load = ld; seg_in = s; dp_in = d; dig_en = en;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; seg_in = '0; dp_in = '0; dig_en = 4'hF;
        pos = 0; m_pv = 0;
        m_act_seg = '0; m_act_dp = '0; m_pend_seg = '0; m_pend_dp = '0;

        // Directed: reset, then the reference digit pattern with all digits on.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0, '0, 4'hF);
            cycle_check();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, '0, 4'hF);
            cycle_check();
        end
        check_val("post_reset_on_an", 32'(an_n), 32'h0000_000E);
        drive(1'b0, 1'b1, {7'h79, 7'h6D, 7'h30, 7'h7E}, 4'b0100, 4'hF);
        cycle_check();
        for (int i = 0; i < 3 * FRAME; i++) begin
            drive(1'b0, 1'b0, '0, '0, (i >= 2 * FRAME) ? 4'b1010 : 4'hF);
            cycle_check();
        end

        // Randomized: loads biased toward the frame boundary, occasional resets.
        for (int i = 0; i < 4000; i++) begin
            logic        r, ld;
            logic [3:0]  en;
            r  = ($urandom_range(0, 299) == 0);
            ld = (pos == FRAME - 1) ? ($urandom_range(0, 1) == 1)
                                    : ($urandom_range(0, 19) == 0);
            en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : dig_en;
            drive(r, ld, 28'($urandom), 4'($urandom), en);
            cycle_check();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range CLK_DIV >= 2.
REQ-002 Parameter BLANK_CYCLES, default 1000, anti-ghost blank cycles at the start of each slot; legal range 1 <= BLANK_CYCLES < CLK_DIV.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 seg_in  input  28  four active-high segment patterns; digit d = seg_in[7d+6:7d], bit 6 = a … bit 0 = g (hex-to-7seg decoder output format).
REQ-006 dp_in  input  4  decimal point per digit, active-high.
REQ-007 dig_en  input  4  per-digit enable, sampled live every cycle (not shadowed).
REQ-008 load  input  1  single-cycle strobe; captures seg_in/dp_in into the pending register.
REQ-009 an_n  output  4  digit anodes, active-low, registered.
REQ-010 seg_n  output  7  cathodes, active-low, same bit order as seg_in, registered.
REQ-011 dp_n  output  1  decimal point cathode, active-low, registered.
REQ-012 update_done  output  1  one-cycle pulse when pending data becomes active.
REQ-013 frame_tick  output  1  one-cycle pulse on the first cycle of each digit-0 slot.

Function
REQ-014 The block SHALL hold a slot counter cnt (0..CLK_DIV-1) and a digit index idx (0..3); cnt wraps to 0 after CLK_DIV-1, idx increments on that wrap and wraps 3->0.
REQ-015 The block SHALL implement two states per slot: BLANK while cnt < BLANK_CYCLES, ON while cnt >= BLANK_CYCLES.
REQ-016 In BLANK, outputs SHALL be an_n=4'hF, seg_n=7'h7F, dp_n=1.
REQ-017 In ON with dig_en[idx]=1, outputs SHALL be an_n[idx]=0 (others 1), seg_n=~active_seg[idx], dp_n=~active_dp[idx]; with dig_en[idx]=0, outputs SHALL be as in BLANK.
REQ-018 Outputs SHALL be registered: values reflect cnt/idx/state of the preceding cycle (1-cycle latency).
REQ-019 Slot timing SHALL be independent of dig_en; a frame is exactly 4*CLK_DIV cycles.
REQ-020 load=1 SHALL write seg_in/dp_in into pending and set pending_valid; multiple loads within one frame: last wins.
REQ-021 Frame boundary = cycle where idx=3 and cnt=CLK_DIV-1; if pending_valid, active SHALL take pending, pending_valid SHALL clear, update_done SHALL pulse on the next cycle.
REQ-022 load in the boundary cycle: active SHALL take the pre-cycle pending content; the new value SHALL land in pending with pending_valid=1 and apply at the following boundary.
REQ-023 load in the boundary cycle with pending_valid=0: no transfer that boundary; the new value applies at the following boundary.
REQ-024 frame_tick SHALL pulse in the same cycle as update_done would (cycle after the boundary), regardless of pending_valid.
REQ-025 Active data SHALL never change mid-frame (no tearing).

Reset
REQ-026 While rst=1 (sampled on clk): cnt=0, idx=0, state BLANK, active and pending cleared to 0, pending_valid=0; on the following edge an_n=4'hF, seg_n=7'h7F, dp_n=1, update_done=0, frame_tick=0.
REQ-027 rst SHALL override load and any mid-slot/mid-frame activity; the first post-reset slot is digit 0 starting with BLANK_CYCLES blank cycles.

Verification (CLK_DIV=8, BLANK_CYCLES=2)
REQ-028 rst high 3 cycles then low -> an_n=F, seg_n=7F, dp_n=1 throughout reset and first 2 cycles after; active=0 so ON shows seg_n=7F, an_n=4'b1110 from cycle 3.
REQ-029 load with digits 0..3 = 7'h7E,7'h30,7'h6D,7'h79, dp_in=4'b0100, dig_en=F -> update_done 1 cycle after next boundary; digit-2 ON phase: an_n=4'b1011, seg_n=7'h12, dp_n=0; each anode low 6 of every 8 cycles, period 32.
REQ-030 dig_en=4'b1010 -> an_n[0], an_n[2] never low; an_n[1] low cycles 11..16 of frame relative to frame_tick; period remains 32.
REQ-031 load A then load B in boundary cycle -> A displayed for one frame, B the next; two update_done pulses exactly 32 cycles apart.
REQ-032 rst asserted during digit-1 ON phase -> next edge all outputs off, idx=0, pending_valid=0; prior pending never displayed.
REQ-033 Three loads within one frame -> single update_done; only the third value displayed.
